lfsr_multi: RTL and testbench
=============================

Name: lfsr_multi

Overview:
Multi-channel successor to the single-channel fixed-point LFSR generator used to seed LBM lattice populations with random perturbations. N_CHANNELS independent Galois LFSRs each produce a uniform random fraction. Each fraction is scaled by a signed fixed-point Scale in unipolar [0,Scale) or bipolar [-Scale,Scale) mode. The block emits a counted burst of sample-sets under a valid/ready handshake and pulses LFSR_Done when the burst completes.

Parameters:
DATA_WIDTH, 64, fixed-point word width
FRACTIONAL_BITS, 56, fractional bits of Scale/Dout (Q8.56)
INTEGER_BITS, DATA_WIDTH-FRACTIONAL_BITS, integer bits incl. sign
LFSR_WIDTH, 32, LFSR state width
TAPS, 32'h80200003, Galois feedback mask (x^32+x^22+x^2+x+1, maximal)
N_CHANNELS, 4, number of parallel LFSR channels
COUNT_WIDTH, 16, width of burst length
DEFAULT_SEED, 32'hACE1_2468, seed applied at reset

Ports:
Clk  in  1  clock, rising edge
Reset_n  in  1  synchronous active-low reset
Seed_Load  in  1  load Seed into all channels (IDLE only)
Seed  in  LFSR_WIDTH  base seed
Start  in  1  begin burst (IDLE only)
Count  in  COUNT_WIDTH  sample-sets in burst
Scale  in  DATA_WIDTH  signed Q8.56 amplitude
Mode  in  1  0=unipolar, 1=bipolar
Out_Ready  in  1  downstream accepts sample-set
Out_Valid  out  1  Dout holds a valid sample-set
Dout  out  N_CHANNELS*DATA_WIDTH  channel k at bits [k*DATA_WIDTH +: DATA_WIDTH], signed Q8.56
Busy  out  1  burst in progress
LFSR_Done  out  1  one-cycle pulse at burst end

Behaviour:
- Reset (Reset_n=0 at edge): Out_Valid=0, Dout=0, Busy=0, LFSR_Done=0, FSM=IDLE, state[k]=DEFAULT_SEED^SALT(k). Reset mid-burst aborts the burst with no Done pulse and discards any loaded seed.
- SALT(k)=k*32'h9E3779B9 (mod 2^32); SALT(0)=0. A seed that salts to 0 is replaced by 32'h1 (lock-up guard).
- Seed_Load in IDLE: state[k]=Seed^SALT(k) next edge. Ignored outside IDLE. Seed_Load has priority over Start in the same cycle; that Start is dropped.
- LFSR step: lsb=s[0]; s=s>>1; if lsb, s^=TAPS. Channels step together, only on advance.
- FSM IDLE->RUN on Start with Count!=0: latch Scale, Mode, Count; Busy=1 next cycle. Start with Count==0: IDLE->DONE, no Out_Valid.
- Start while Busy is ignored.
- RUN: a 2-stage pipeline. Stage 1 steps the LFSRs. Stage 2 registers the scaled product. First Out_Valid appears 2 cycles after the Start-accept edge.
- With Out_Ready=1, throughput is one sample-set per cycle.
- Stall: Out_Valid&&!Out_Ready freezes the LFSRs, both pipeline stages and Dout. No sample is skipped or duplicated, so the sequence is identical to a stall-free run.
- Arithmetic, u=post-step state[k]:
  - Mode 0: Dout=(Scale*{1'b0,u})>>>LFSR_WIDTH.
  - Mode 1: Dout=(Scale*$signed(u))>>>(LFSR_WIDTH-1).
  - Full product width DATA_WIDTH+LFSR_WIDTH+1; truncate toward -inf, no saturation.
- Exactly Count handshakes (Out_Valid&&Out_Ready) are issued; the pipeline does not prefetch beyond Count.
- After the last handshake: Out_Valid=0. The next cycle is DONE: LFSR_Done=1 and Busy=0. Then IDLE.
- LFSR state persists between bursts; a new burst continues the sequence.

Decomposition:
- Package lfsr_pkg: FSM enum {IDLE,RUN,DONE}, default TAPS, DEFAULT_SEED, salt constant 32'h9E3779B9, function salt_seed(seed,k) with zero guard.
- Sub-module lfsr_core: one channel, with a state register, load, advance enable and a Galois step. Instantiated N_CHANNELS times via generate.
- Top level holds the FSM, counter, multipliers and output registers.

Test Plan:
1. Reset; Seed_Load Seed=0 (ch0 state=1); Start Count=1, Mode=0, Scale=64'h02000000_00000000, Out_Ready=1 -> ch0 Dout=64'h01004000_06000000, Out_Valid one cycle, LFSR_Done next cycle.
2. Same reset and seed, Mode=1 -> ch0 Dout=64'hFE008000_0C000000 (about -1.998).
3. Start Count=0 -> no Out_Valid; LFSR_Done pulses once 1 cycle after Start; Busy stays 0.
4. Count=5, Out_Ready=1 -> Out_Valid high exactly 5 consecutive cycles; LFSR_Done one cycle after last; Start during Busy has no effect.
5. Count=4, Out_Ready low 3 cycles mid-burst -> Dout/Out_Valid frozen during stall; the 4 sample-sets match the stall-free run of test 4's first 4.
6. Assert Reset_n=0 mid-burst -> next cycle Out_Valid=0, Dout=0, Busy=0, no LFSR_Done; Seed_Load during Busy ignored (verify via sequence).

Source files
------------

// File: rtl/lfsr_pkg.sv
// Shared types and constants for the multi-channel fixed-point LFSR generator.
// Seed salting gives each channel its own start point from one base seed.
package lfsr_pkg;

   localparam logic [31:0] DEF_TAPS = 32'h8020_0003;
   localparam logic [31:0] DEF_SEED = 32'hACE1_2468;
   localparam logic [31:0] SALT_K   = 32'h9E37_79B9;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } fsm_t;

   // An all-zero state would lock a Galois LFSR, so it is replaced by 1.
   function automatic logic [31:0] salt_seed(input logic [31:0] seed, input int k);
      logic [31:0] kk;
      logic [31:0] s;
      kk = k[31:0];
      s  = seed ^ (kk * SALT_K);
      return (s == 32'd0) ? 32'd1 : s;
   endfunction

endpackage

// File: rtl/lfsr_core.sv
// One Galois LFSR channel: reset value, synchronous load, step on advance.
// Load wins over advance; state holds when neither is asserted.
module lfsr_core #(
   parameter int                 WIDTH     = 32,
   parameter logic [WIDTH-1:0]   TAPS      = 32'h8020_0003,
   parameter logic [WIDTH-1:0]   RESET_VAL = 32'h0000_0001
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             advance,
   output logic [WIDTH-1:0] state
);

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state <= RESET_VAL;
      end else if (load) begin
         state <= load_val;
      end else if (advance) begin
         state <= (state >> 1) ^ (state[0] ? TAPS : '0);
      end
   end

endmodule

// File: rtl/lfsr_multi.sv
// N parallel LFSRs scaled by a signed Q8.56 amplitude; first sample 2 cycles after Start.
// Out_Valid && !Out_Ready freezes LFSRs, both pipeline stages and Dout.
module lfsr_multi import lfsr_pkg::*; #(
   parameter int                    DATA_WIDTH      = 64,
   parameter int                    FRACTIONAL_BITS = 56,
   parameter int                    INTEGER_BITS    = DATA_WIDTH - FRACTIONAL_BITS,
   parameter int                    LFSR_WIDTH      = 32,
   parameter logic [LFSR_WIDTH-1:0] TAPS            = DEF_TAPS,
   parameter int                    N_CHANNELS      = 4,
   parameter int                    COUNT_WIDTH     = 16,
   parameter logic [LFSR_WIDTH-1:0] DEFAULT_SEED    = DEF_SEED
) (
   input  logic                             Clk,
   input  logic                             Reset_n,
   input  logic                             Seed_Load,
   input  logic [LFSR_WIDTH-1:0]            Seed,
   input  logic                             Start,
   input  logic [COUNT_WIDTH-1:0]           Count,
   input  logic [DATA_WIDTH-1:0]            Scale,
   input  logic                             Mode,
   input  logic                             Out_Ready,
   output logic                             Out_Valid,
   output logic [N_CHANNELS*DATA_WIDTH-1:0] Dout,
   output logic                             Busy,
   output logic                             LFSR_Done
);

   localparam int PW = DATA_WIDTH + LFSR_WIDTH + 1;

   if (INTEGER_BITS + FRACTIONAL_BITS != DATA_WIDTH) begin : g_bad_format
      $error("lfsr_multi: INTEGER_BITS + FRACTIONAL_BITS must equal DATA_WIDTH");
   end

   fsm_t                            state;
   logic [COUNT_WIDTH-1:0]          issue_left;
   logic [COUNT_WIDTH-1:0]          out_left;
   logic                            s1_vld;
   logic [DATA_WIDTH-1:0]           scale_q;
   logic                            mode_q;
   logic                            en;
   logic                            fire;
   logic                            load;
   logic                            accept;
   logic                            step;
   logic [LFSR_WIDTH-1:0]           lfsr_state [N_CHANNELS];
   logic [N_CHANNELS*DATA_WIDTH-1:0] scaled;

   assign en     = !Out_Valid || Out_Ready;
   assign fire   = Out_Valid && Out_Ready;
   assign load   = (state == IDLE) && Seed_Load;
   assign accept = (state == IDLE) && Start && !Seed_Load;
   assign step   = (state == RUN) && en && (issue_left != '0);

   for (genvar k = 0; k < N_CHANNELS; k++) begin : g_ch
      logic signed [PW-1:0] prod_uni;
      logic signed [PW-1:0] prod_bi;
      logic                 unused_prod;

      lfsr_core #(
         .WIDTH     (LFSR_WIDTH),
         .TAPS      (TAPS),
         .RESET_VAL (salt_seed(DEFAULT_SEED, k))
      ) u_core (
         .clk      (Clk),
         .reset_n  (Reset_n),
         .load     (load),
         .load_val (salt_seed(Seed, k)),
         .advance  (step),
         .state    (lfsr_state[k])
      );

      // Taking the slice above the shift amount equals an arithmetic shift (floor).
      assign prod_uni = $signed(scale_q) * $signed({1'b0, lfsr_state[k]});
      assign prod_bi  = $signed(scale_q) * $signed(lfsr_state[k]);
      assign scaled[k*DATA_WIDTH +: DATA_WIDTH] = mode_q ? prod_bi[LFSR_WIDTH-1 +: DATA_WIDTH]
                                                         : prod_uni[LFSR_WIDTH +: DATA_WIDTH];
      assign unused_prod = ^{prod_uni[PW-1], prod_uni[LFSR_WIDTH-1:0],
                             prod_bi[PW-1:PW-2], prod_bi[LFSR_WIDTH-2:0]};
   end

   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         state      <= IDLE;
         issue_left <= '0;
         out_left   <= '0;
         s1_vld     <= 1'b0;
         scale_q    <= '0;
         mode_q     <= 1'b0;
         Out_Valid  <= 1'b0;
         Dout       <= '0;
         Busy       <= 1'b0;
         LFSR_Done  <= 1'b0;
      end else begin
         LFSR_Done <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  if (Count == '0) begin
                     state     <= DONE;
                     LFSR_Done <= 1'b1;
                  end else begin
                     state      <= RUN;
                     Busy       <= 1'b1;
                     issue_left <= Count;
                     out_left   <= Count;
                     scale_q    <= Scale;
                     mode_q     <= Mode;
                  end
               end
            end
            RUN: begin
               if (en) begin
                  s1_vld    <= step;
                  Out_Valid <= s1_vld;
                  if (s1_vld) Dout <= scaled;
               end
               if (step) issue_left <= issue_left - 1'b1;
               // Issue count caps the pipeline, so the final handshake always drains it.
               if (fire) begin
                  out_left <= out_left - 1'b1;
                  if (out_left == 1) begin
                     state     <= DONE;
                     Busy      <= 1'b0;
                     LFSR_Done <= 1'b1;
                  end
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lfsr_multi.sv
// Directed bench for lfsr_multi: reference LFSR/scale model plus hand-computed anchors.
module tb_lfsr_multi;

   localparam int NCH = 4;
   localparam int DW  = 64;

   logic            Clk = 1'b0;
   logic            Reset_n;
   logic            Seed_Load;
   logic [31:0]     Seed;
   logic            Start;
   logic [15:0]     Count;
   logic [63:0]     Scale;
   logic            Mode;
   logic            Out_Ready;
   logic            Out_Valid;
   logic [255:0]    Dout;
   logic            Busy;
   logic            LFSR_Done;

   int              n_checks = 0;
   int              n_errors = 0;
   logic [31:0]     mstate [NCH];
   logic [63:0]     first_ch0;

   lfsr_multi dut (
      .Clk       (Clk),
      .Reset_n   (Reset_n),
      .Seed_Load (Seed_Load),
      .Seed      (Seed),
      .Start     (Start),
      .Count     (Count),
      .Scale     (Scale),
      .Mode      (Mode),
      .Out_Ready (Out_Ready),
      .Out_Valid (Out_Valid),
      .Dout      (Dout),
      .Busy      (Busy),
      .LFSR_Done (LFSR_Done)
   );

   always #5 Clk = ~Clk;

   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] m_salt(input logic [31:0] seed, input int k);
      logic [31:0] kk;
      logic [31:0] s;
      kk = k;
      s  = seed ^ (kk * 32'h9E3779B9);
      if (s == 32'd0) s = 32'd1;
      return s;
   endfunction

   function automatic logic [31:0] m_step(input logic [31:0] u);
      return u[0] ? ((u >> 1) ^ 32'h80200003) : (u >> 1);
   endfunction

   function automatic logic [63:0] m_scale(input logic [63:0] scl, input logic md, input logic [31:0] u);
      logic signed [96:0] a;
      logic signed [96:0] b;
      logic signed [96:0] p;
      a = {{33{scl[63]}}, scl};
      b = md ? {{65{u[31]}}, u} : {65'd0, u};
      p = a * b;
      p = md ? (p >>> 31) : (p >>> 32);
      return p[63:0];
   endfunction

   task automatic model_seed(input logic [31:0] s);
      for (int k = 0; k < NCH; k++) mstate[k] = m_salt(s, k);
   endtask

   function automatic logic [255:0] model_next(input logic [63:0] scl, input logic md);
      logic [255:0] v;
      v = '0;
      for (int k = 0; k < NCH; k++) v[k*DW +: DW] = m_scale(scl, md, m_step(mstate[k]));
      return v;
   endfunction

   task automatic do_reset();
      Reset_n = 1'b0; Seed_Load = 1'b0; Seed = '0; Start = 1'b0; Count = '0;
      Scale = '0; Mode = 1'b0; Out_Ready = 1'b1;
      repeat (2) @(posedge Clk);
      #1;
      check("rst_valid", Out_Valid, 1'b0);
      check("rst_dout",  Dout, '0);
      check("rst_busy",  Busy, 1'b0);
      check("rst_done",  LFSR_Done, 1'b0);
      Reset_n = 1'b1;
      model_seed(32'hACE12468);
   endtask

   task automatic load_seed(input logic [31:0] s);
      Seed_Load = 1'b1; Seed = s;
      @(posedge Clk); #1;
      Seed_Load = 1'b0;
      model_seed(s);
   endtask

   // Runs one burst; optional mid-burst Start poke, Seed_Load poke, stall window or reset abort.
   task automatic run_burst(input string tag, input int cnt, input logic [63:0] scl, input logic md,
                            input int stall_after, input int stall_len, input bit poke,
                            input int abort_after);
      int cyc, got, n_vld, first, stall_left;
      bit aborted, done_seen;
      logic [255:0] exp;
      Count = cnt[15:0]; Scale = scl; Mode = md; Out_Ready = 1'b1; Start = 1'b1;
      @(posedge Clk); #1;
      Start = 1'b0;
      if (cnt == 0) begin
         check({tag, "_done0"},  LFSR_Done, 1'b1);
         check({tag, "_busy0"},  Busy, 1'b0);
         check({tag, "_valid0"}, Out_Valid, 1'b0);
         @(posedge Clk); #1;
         check({tag, "_done_off"}, LFSR_Done, 1'b0);
         return;
      end
      check({tag, "_busy"}, Busy, 1'b1);
      cyc = 0; got = 0; n_vld = 0; first = -1; stall_left = stall_len; aborted = 0;
      while (got < cnt && cyc < 200) begin
         @(posedge Clk); #1;
         cyc++;
         Start = (poke && cyc == 3);
         Count = (poke && cyc == 3) ? 16'd7 : cnt[15:0];
         Seed_Load = (abort_after >= 0 && cyc == 4);
         Seed = 32'h0BADF00D;
         if (Out_Valid) begin
            if (first < 0) first = cyc;
            n_vld++;
            exp = model_next(scl, md);
            check($sformatf("%s_s%0d", tag, got), Dout, exp);
         end
         if (abort_after >= 0 && got == abort_after) begin
            aborted = 1;
            break;
         end
         Out_Ready = !(Out_Valid && got == stall_after && stall_left > 0);
         if (!Out_Ready) stall_left--;
         if (Out_Valid && Out_Ready) begin
            if (got == 0) first_ch0 = Dout[63:0];
            for (int k = 0; k < NCH; k++) mstate[k] = m_step(mstate[k]);
            got++;
         end
      end
      Start = 1'b0; Seed_Load = 1'b0; Out_Ready = 1'b1;
      if (cyc >= 200) check({tag, "_timeout"}, 1'b1, 1'b0);
      if (aborted) begin
         Reset_n = 1'b0;
         @(posedge Clk); #1;
         Reset_n = 1'b1;
         check({tag, "_abort_valid"}, Out_Valid, 1'b0);
         check({tag, "_abort_dout"},  Dout, '0);
         check({tag, "_abort_busy"},  Busy, 1'b0);
         done_seen = LFSR_Done;
         repeat (3) begin
            @(posedge Clk); #1;
            done_seen |= LFSR_Done;
         end
         check({tag, "_abort_nodone"}, done_seen, 1'b0);
         model_seed(32'hACE12468);
         return;
      end
      check({tag, "_latency"}, first, 2);
      check({tag, "_nvalid"}, n_vld, cnt + stall_len);
      @(posedge Clk); #1;
      check({tag, "_end_valid"}, Out_Valid, 1'b0);
      check({tag, "_end_done"},  LFSR_Done, 1'b1);
      check({tag, "_end_busy"},  Busy, 1'b0);
      @(posedge Clk); #1;
      check({tag, "_done_pulse"}, LFSR_Done, 1'b0);
   endtask

   initial begin
      // Unipolar anchor: seed 0 salts to state 1, one step gives 0x80200003.
      do_reset();
      load_seed(32'h0);
      run_burst("t1", 1, 64'h02000000_00000000, 1'b0, -1, 0, 0, -1);
      check("t1_ch0_hand", first_ch0, 64'h01004000_06000000);

      do_reset();
      load_seed(32'h0);
      run_burst("t2", 1, 64'h02000000_00000000, 1'b1, -1, 0, 0, -1);
      check("t2_ch0_hand", first_ch0, 64'hFE008000_0C000000);

      run_burst("t3", 0, 64'h02000000_00000000, 1'b0, -1, 0, 0, -1);

      do_reset();
      load_seed(32'h13579BDF);
      run_burst("t4", 5, 64'h01234567_89ABCDEF, 1'b0, -1, 0, 1, -1);

      do_reset();
      load_seed(32'h13579BDF);
      run_burst("t5", 4, 64'h01234567_89ABCDEF, 1'b0, 1, 3, 0, -1);

      do_reset();
      run_burst("t6", 10, 64'hFE800000_00000000, 1'b1, -1, 0, 0, 4);
      run_burst("t6_post", 2, 64'hFE800000_00000000, 1'b1, -1, 0, 0, -1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
